// File: rtl/scroll_pkg.sv
// Shared constants, state payload and score-to-BCD helper for the scroll controller.
package scroll_pkg;

    localparam int unsigned SCREEN_H_DEF     = 480;
    localparam int unsigned STEP_DEF         = 2;
    localparam int unsigned TICK_BASE_DEF    = 100000;
    localparam int unsigned TICK_DEC_DEF     = 10000;
    localparam int unsigned TICK_MIN_DEF     = 40000;
    localparam int unsigned TICKS_PER_PT_DEF = 100;
    localparam int unsigned PTS_PER_LVL_DEF  = 10;
    localparam int unsigned SCORE_MAX_DEF    = 99;

    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned SCORE_W = 7;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned CTR_W   = 18;
    localparam int unsigned BCD_W   = 8;

    typedef struct packed {
        logic [POS_W-1:0]   y;
        logic [SCORE_W-1:0] score;
        logic [LEVEL_W-1:0] level;
    } scroll_state_t;

    // Two-digit packed BCD; score never exceeds 99.
    function automatic logic [BCD_W-1:0] to_bcd(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] tens;
        logic [SCORE_W-1:0] units;
        tens  = v / SCORE_W'(10);
        units = v - (tens * SCORE_W'(10));
        return {4'(tens), 4'(units)};
    endfunction

endpackage

// File: rtl/scroll_ctrl_tick_gen.sv
// Move-tick generator: counts clk cycles while scrolling and emits one pulse per period.
module tick_gen
    import scroll_pkg::*;
#(
    parameter int unsigned TICK_BASE = TICK_BASE_DEF,
    parameter int unsigned TICK_DEC  = TICK_DEC_DEF,
    parameter int unsigned TICK_MIN  = TICK_MIN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active_i,
    input  logic               restart_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic               fire_c,
    output logic               pulse_o
);

    localparam int unsigned SPAN = (TICK_BASE > TICK_MIN) ? (TICK_BASE - TICK_MIN) : 0;

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;
    logic [CTR_W-1:0] period_q;
    logic [CTR_W-1:0] period_d;
    logic [CTR_W-1:0] period_c;
    logic [CTR_W-1:0] eff_period_c;
    logic [31:0]      dec_c;

    // Level-scaled period with a floor.
    always_comb begin
        dec_c = 32'(level_i) * 32'(TICK_DEC);
        if (dec_c >= 32'(SPAN)) begin
            period_c = CTR_W'(TICK_MIN);
        end else begin
            period_c = CTR_W'(TICK_BASE - dec_c);
        end
    end

    // The first cycle of a period uses the live level; the rest use the captured value.
    assign eff_period_c = (ctr_q == '0) ? period_c : period_q;
    assign fire_c       = active_i && !restart_i && (ctr_q == (eff_period_c - CTR_W'(1)));

    always_comb begin
        ctr_d    = ctr_q + CTR_W'(1);
        period_d = period_q;
        if (ctr_q == '0) begin
            period_d = period_c;
        end
        if (!active_i || restart_i || fire_c) begin
            ctr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q    <= '0;
            period_q <= CTR_W'(TICK_BASE);
            pulse_o  <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            period_q <= period_d;
            pulse_o  <= fire_c;
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll controller: wrapped vertical offset, tick-driven score and level progression.
// Optional SCROLL_BCD_EN adds a registered two-digit BCD copy of the score.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int unsigned SCREEN_H     = SCREEN_H_DEF,
    parameter int unsigned STEP         = STEP_DEF,
    parameter int unsigned TICK_BASE    = TICK_BASE_DEF,
    parameter int unsigned TICK_DEC     = TICK_DEC_DEF,
    parameter int unsigned TICK_MIN     = TICK_MIN_DEF,
    parameter int unsigned TICKS_PER_PT = TICKS_PER_PT_DEF,
    parameter int unsigned PTS_PER_LVL  = PTS_PER_LVL_DEF,
    parameter int unsigned SCORE_MAX    = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               move_btn,
    input  logic               restart,
    output logic [POS_W-1:0]   y_pos,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic               move_followers,
    output logic               wrap
`ifdef SCROLL_BCD_EN
    ,
    output logic [BCD_W-1:0]   score_bcd
`endif
);

    localparam int unsigned SUM_W = POS_W + 1;
    localparam int unsigned CNT_W = $clog2(TICKS_PER_PT + 1);
    localparam int unsigned PTS_W = $clog2(PTS_PER_LVL + 1);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic             move_active_q;
    logic             fire_c;
    scroll_state_t    st_q;
    scroll_state_t    st_d;
    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;
    logic [PTS_W-1:0] pts_q;
    logic [PTS_W-1:0] pts_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [SUM_W-1:0] pos_sum;

    // Asynchronous assertion, release aligned to clk after two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    tick_gen #(
        .TICK_BASE (TICK_BASE),
        .TICK_DEC  (TICK_DEC),
        .TICK_MIN  (TICK_MIN)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .active_i  (move_active_q),
        .restart_i (restart),
        .level_i   (st_q.level),
        .fire_c    (fire_c),
        .pulse_o   (move_followers)
    );

    // Position wrap, score accrual and level promotion on each tick; restart wins.
    always_comb begin
        st_d       = st_q;
        tick_cnt_d = tick_cnt_q;
        pts_d      = pts_q;
        wrap_d     = 1'b0;
        pos_sum    = SUM_W'(st_q.y) + SUM_W'(STEP);
        if (restart) begin
            st_d       = '0;
            tick_cnt_d = '0;
            pts_d      = '0;
        end else if (fire_c) begin
            if (pos_sum < SUM_W'(SCREEN_H)) begin
                st_d.y = POS_W'(pos_sum);
            end else begin
                st_d.y = POS_W'(pos_sum - SUM_W'(SCREEN_H));
                wrap_d = 1'b1;
            end
            if (tick_cnt_q == CNT_W'(TICKS_PER_PT - 1)) begin
                tick_cnt_d = '0;
                if (st_q.score < SCORE_W'(SCORE_MAX)) begin
                    st_d.score = st_q.score + SCORE_W'(1);
                    if (pts_q == PTS_W'(PTS_PER_LVL - 1)) begin
                        pts_d = '0;
                        if (st_q.level != '1) begin
                            st_d.level = st_q.level + LEVEL_W'(1);
                        end
                    end else begin
                        pts_d = pts_q + PTS_W'(1);
                    end
                end
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            move_active_q <= 1'b0;
            st_q          <= '0;
            tick_cnt_q    <= '0;
            pts_q         <= '0;
            wrap_q        <= 1'b0;
        end else begin
            move_active_q <= move_btn;
            st_q          <= st_d;
            tick_cnt_q    <= tick_cnt_d;
            pts_q         <= pts_d;
            wrap_q        <= wrap_d;
        end
    end

    assign y_pos = st_q.y;
    assign score = st_q.score;
    assign level = st_q.level;
    assign wrap  = wrap_q;

`ifdef SCROLL_BCD_EN
    logic [BCD_W-1:0] bcd_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= to_bcd(st_d.score);
        end
    end
    assign score_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl with small periods: tick timing, wrap, levels, restart, saturation.
module tb_scroll_ctrl;
    import scroll_pkg::*;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               move_btn = 1'b0;
    logic               restart  = 1'b0;
    logic [POS_W-1:0]   y_pos;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;
    logic               move_followers;
    logic               wrap;
`ifdef SCROLL_BCD_EN
    logic [BCD_W-1:0]   score_bcd;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    scroll_ctrl #(
        .SCREEN_H     (10),
        .STEP         (3),
        .TICK_BASE    (8),
        .TICK_DEC     (2),
        .TICK_MIN     (4),
        .TICKS_PER_PT (2),
        .PTS_PER_LVL  (2),
        .SCORE_MAX    (99)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .move_btn       (move_btn),
        .restart        (restart),
        .y_pos          (y_pos),
        .score          (score),
        .level          (level),
        .move_followers (move_followers),
        .wrap           (wrap)
`ifdef SCROLL_BCD_EN
        ,
        .score_bcd      (score_bcd)
`endif
    );

    typedef struct {
        int gap;
        int y;
        int wr;
        int sc;
        int lv;
    } tick_vec_t;

    tick_vec_t vecs [14];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycles (negedges) until the next move_followers pulse; -1 on timeout.
    task automatic wait_tick(output int cyc, output int stray);
        cyc   = -1;
        stray = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (wrap && !move_followers) stray++;
            if (move_followers) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int g;
        int sw;
        int seen;
        int ticks;
        int y_m;

        // gap from previous tick (first: from move_btn rise), then state after the tick
        vecs[0]  = '{9, 3, 0, 0, 0};
        vecs[1]  = '{8, 6, 0, 1, 0};
        vecs[2]  = '{8, 9, 0, 1, 0};
        vecs[3]  = '{8, 2, 1, 2, 1};
        vecs[4]  = '{6, 5, 0, 2, 1};
        vecs[5]  = '{6, 8, 0, 3, 1};
        vecs[6]  = '{6, 1, 1, 3, 1};
        vecs[7]  = '{6, 4, 0, 4, 2};
        vecs[8]  = '{4, 7, 0, 4, 2};
        vecs[9]  = '{4, 0, 1, 5, 2};
        vecs[10] = '{4, 3, 0, 5, 2};
        vecs[11] = '{4, 6, 0, 6, 3};
        vecs[12] = '{4, 9, 0, 6, 3};
        vecs[13] = '{4, 2, 1, 7, 3};

        repeat (3) @(negedge clk);
        check("rst_y", int'(y_pos), 0);
        check("rst_score", int'(score), 0);
        check("rst_level", int'(level), 0);
        check("rst_mf", int'(move_followers), 0);
        check("rst_wrap", int'(wrap), 0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_y", int'(y_pos), 0);
        check("post_rst_mf", int'(move_followers), 0);

        move_btn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wait_tick(g, sw);
            check($sformatf("gap[%0d]", i), g, vecs[i].gap);
            check($sformatf("y[%0d]", i), int'(y_pos), vecs[i].y);
            check($sformatf("wrap[%0d]", i), int'(wrap), vecs[i].wr);
            check($sformatf("score[%0d]", i), int'(score), vecs[i].sc);
            check($sformatf("level[%0d]", i), int'(level), vecs[i].lv);
            check($sformatf("stray_wrap[%0d]", i), sw, 0);
        end
`ifdef SCROLL_BCD_EN
        check("bcd_7", int'(score_bcd), 8'h07);
`endif

        // Restart lands on the edge where the next period-4 tick would fire.
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_y", int'(y_pos), 0);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 0);
        check("restart_mf", int'(move_followers), 0);
        check("restart_wrap", int'(wrap), 0);

        // Drop move_btn with ctr=5 of an 8-cycle period, idle, then re-raise.
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (move_followers) seen++;
        end
        move_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (move_followers || (y_pos != '0)) seen++;
        end
        check("idle_activity", seen, 0);
        check("idle_y", int'(y_pos), 0);
        move_btn = 1'b1;
        wait_tick(g, sw);
        check("reraise_gap", g, 9);
        check("reraise_y", int'(y_pos), 3);
        check("reraise_score", int'(score), 0);

        // Run to score saturation: one tick finishes the current point, then 2 per point.
        ticks = 0;
        y_m   = 3;
        while ((score != SCORE_W'(99)) && (ticks < 300)) begin
            wait_tick(g, sw);
            if (g < 0) break;
            ticks++;
            y_m += 3;
            if (y_m >= 10) y_m -= 10;
        end
        check("ticks_to_max", ticks, 197);
        check("score_max", int'(score), 99);
        check("level_at_max", int'(level), 15);
        check("y_model_at_max", int'(y_pos), y_m);
        for (int i = 0; i < 6; i++) begin
            wait_tick(g, sw);
            y_m += 3;
            if (y_m >= 10) y_m -= 10;
            check($sformatf("sat_gap[%0d]", i), g, 4);
            check($sformatf("sat_score[%0d]", i), int'(score), 99);
            check($sformatf("sat_level[%0d]", i), int'(level), 15);
        end
        check("y_model_final", int'(y_pos), y_m);
`ifdef SCROLL_BCD_EN
        check("bcd_99", int'(score_bcd), 8'h99);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
